mem_param: RTL and testbench
============================

Name: mem_param

Overview:
- Parametrised successor to the team's byte-addressed, big-endian data memory.
- Adds configurable address width and word width (bytes per word), byte-mode accesses, and a read-valid strobe.
- Adds a hardware init sequencer that clears the array after reset, so there is no single-cycle reset loop; a ready flag reports when init is done.
- Sits between the datapath load/store stage and the register file write-back path.

Parameters:
- ADDR_W, 8: byte-address width; array depth = 2**ADDR_W bytes.
- BYTES_PER_WORD, 2: bytes per word; legal values 1, 2, 4; DW = 8*BYTES_PER_WORD.
- CLR_VALUE, 8'h00: byte value written to every location during init.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  read request, sampled on a rising edge while ready=1.
- MemWrite  input  1  write request, sampled on a rising edge while ready=1.
- ByteMode  input  1  1 = single-byte access; 0 = full-word access.
- addr_in  input  ADDR_W  byte address of the most-significant byte of the access.
- data_in  input  DW  write data; byte mode uses data_in[7:0] only.
- data_out  output  DW  read data register.
- ready  output  1  high when the FSM is in IDLE.
- rd_valid  output  1  one-cycle pulse; data_out is updated in the same cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT, init_ptr=0, data_out=0, rd_valid=0, ready=0.
  - Array contents are not touched by reset itself.
- FSM has two states: INIT and IDLE.
- INIT:
  - Each rising edge writes CLR_VALUE to bytes init_ptr*BPW .. init_ptr*BPW+BPW-1, then init_ptr increments.
  - After the edge that writes the last word (init_ptr = 2**ADDR_W/BPW - 1), the FSM moves to IDLE.
  - INIT therefore lasts exactly 2**ADDR_W/BPW edges; defaults give 128.
  - MemRead/MemWrite are ignored in INIT. Requests are dropped, not queued; data_out holds.
- Reset asserted mid-INIT: init restarts from init_ptr=0.
- IDLE has no exit except reset.
- Byte ordering, word access: byte m[a] maps to data_out/data_in[DW-1:DW-8]; m[a+k] maps to the k-th next-lower byte.
- Address wrap: byte addresses are computed modulo 2**ADDR_W. With ADDR_W=8, BPW=2, addr 8'hFF covers m[FF] (high byte) and m[00] (low byte).
- No alignment requirement on addr_in.
- Byte access:
  - Write: only m[addr_in] <= data_in[7:0].
  - Read: data_out = {zeros, m[addr_in]}, zero-extended.
- Read latency: one edge.
  - Request accepted on edge N loads data_out on edge N; rd_valid=1 for the cycle after edge N.
  - rd_valid returns to 0 on the next edge unless another read is accepted.
- Write: committed on the accepting edge; data_out and rd_valid are unaffected by write-only requests.
- MemRead and MemWrite together: read-before-write.
  - data_out receives the pre-write contents of all addressed bytes, including overlapping bytes.
  - The write is committed on the same edge.
- Neither strobe asserted: no state change; data_out holds; rd_valid=0.
- Back-to-back reads: accepted every cycle; rd_valid stays high.
- Array is held in plain registers with no reset term. Contents before init completes are undefined and unobservable.

Optional Feature:
- Macro: MEM_PRELOAD_EN.
- Defined: during INIT, byte addresses 0..9 receive the table 2B CD 00 00 12 34 DE AD BE EF instead of CLR_VALUE. All other bytes receive CLR_VALUE. INIT length is unchanged.
- Undefined: every byte receives CLR_VALUE. No preload table is synthesised.

Test Plan:
- Init timing (defaults): release reset, count edges.
  - ready=0 for edges 1..127; ready=1 after edge 128.
  - A word read at 8'h40 returns 16'h0000 with a one-cycle rd_valid pulse.
- Init gating: assert MemWrite to 8'h20 with 16'hAAAA at edge 10; after init, read 8'h20 -> 16'h0000. The write was dropped.
- Word write/read plus wrap: write 16'h1234 at 8'hFF, then read 8'hFF -> 16'h1234. Byte read 8'h00 -> 16'h0034; byte read 8'hFF -> 16'h0012.
- Byte mode: write word 16'hDEAD at 8'h10, then byte-write 8'hBE at 8'h11; word read 8'h10 -> 16'hDEBE.
- Simultaneous read/write: with m[30..31]=16'h5555, assert MemRead+MemWrite at 8'h30 with 16'hCAFE.
  - data_out=16'h5555 with rd_valid pulse.
  - Next read -> 16'hCAFE.
- Reset mid-init / preload (MEM_PRELOAD_EN defined): pulse reset low at init edge 60, then wait.
  - ready rises 128 edges after release.
  - Reads at 8'h00, 8'h06, 8'h08 -> 16'h2BCD, 16'hDEAD, 16'hBEEF.
  - Read at 8'h0A -> 16'h0000.

Source files
------------

// File: rtl/mem_param.sv
// mem_param: byte-addressed big-endian data memory with a hardware clear sequencer.
// Define MEM_PRELOAD_EN to seed bytes 0..9 with a fixed table during init.
module mem_param #(
    parameter int          ADDR_W         = 8,
    parameter int          BYTES_PER_WORD = 2,
    parameter logic [7:0]  CLR_VALUE      = 8'h00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          MemRead,
    input  logic                          MemWrite,
    input  logic                          ByteMode,
    input  logic [ADDR_W-1:0]             addr_in,
    input  logic [8*BYTES_PER_WORD-1:0]   data_in,
    output logic [8*BYTES_PER_WORD-1:0]   data_out,
    output logic                          ready,
    output logic                          rd_valid
);
    localparam int DW    = 8*BYTES_PER_WORD;
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH/BYTES_PER_WORD - 1);
    typedef enum logic {INIT, IDLE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] init_ptr;
    logic [ADDR_W-1:0] init_base;
    logic [7:0]        mem [DEPTH];
    logic [DW-1:0]     rd_word;
`ifdef MEM_PRELOAD_EN
    function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR_W'(0): return 8'h2B;
            ADDR_W'(1): return 8'hCD;
            ADDR_W'(4): return 8'h12;
            ADDR_W'(5): return 8'h34;
            ADDR_W'(6): return 8'hDE;
            ADDR_W'(7): return 8'hAD;
            ADDR_W'(8): return 8'hBE;
            ADDR_W'(9): return 8'hEF;
            default:    return CLR_VALUE;
        endcase
    endfunction
`endif
    assign init_base = ADDR_W'(init_ptr * BYTES_PER_WORD);
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++)
            rd_word[DW-1-8*k -: 8] = mem[addr_in + ADDR_W'(k)];
    end
    // Array has no reset term; the sequencer is held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
        end else if (state == INIT) begin
            for (int k = 0; k < BYTES_PER_WORD; k++)
`ifdef MEM_PRELOAD_EN
                mem[init_base + ADDR_W'(k)] <= init_byte(init_base + ADDR_W'(k));
`else
                mem[init_base + ADDR_W'(k)] <= CLR_VALUE;
`endif
        end else if (MemWrite) begin
            if (ByteMode)
                mem[addr_in] <= data_in[7:0];
            else
                for (int k = 0; k < BYTES_PER_WORD; k++)
                    mem[addr_in + ADDR_W'(k)] <= data_in[DW-1-8*k -: 8];
        end
    end
    // Read samples rd_word before the same-edge write lands, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_ptr <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            ready    <= 1'b0;
        end else if (state == INIT) begin
            init_ptr <= init_ptr + 1'b1;
            rd_valid <= 1'b0;
            if (init_ptr == LAST) begin
                state <= IDLE;
                ready <= 1'b1;
            end
        end else begin
            rd_valid <= MemRead;
            if (MemRead)
                data_out <= ByteMode ? {{(DW-8){1'b0}}, mem[addr_in]} : rd_word;
        end
    end
endmodule

// File: tb/tb_mem_param.sv
// tb_mem_param: directed checks of init timing, gating, word/byte access, wrap and RMW ordering.
module tb_mem_param;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, ByteMode = 1'b0;
    logic [7:0]  addr_in = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        ready, rd_valid;
    int          checks = 0, failures = 0;
    int          rise;

    mem_param dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .ByteMode(ByteMode), .addr_in(addr_in), .data_in(data_in),
        .data_out(data_out), .ready(ready), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op(input logic rd, input logic wr, input logic bm,
                      input logic [7:0] a, input logic [15:0] d);
        MemRead = rd; MemWrite = wr; ByteMode = bm; addr_in = a; data_in = d;
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0; ByteMode = 0;
    endtask

    task automatic rd_chk(input string tag, input logic bm, input logic [7:0] a,
                          input logic [15:0] exp);
        op(1, 0, bm, a, 16'h0);
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(data_out), 32'(exp));
    endtask

    initial begin
        #2;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_vld", 32'(rd_valid), 0);
        #10 reset = 1'b1;
        for (int e = 1; e <= 128; e++) begin
            @(posedge clk); #1;
            if (e == 1 || e == 64 || e == 127) chk($sformatf("init_busy_%0d", e), 32'(ready), 0);
            if (e == 9) begin
                MemWrite = 1; MemRead = 1; addr_in = 8'h20; data_in = 16'hAAAA;
            end
            if (e == 10) begin
                MemWrite = 0; MemRead = 0;
                chk("init_rd_ignored", 32'(rd_valid), 0);
            end
        end
        chk("init_done", 32'(ready), 1);
        rd_chk("rd_40", 0, 8'h40, 16'h0000);
        @(posedge clk); #1;
        chk("vld_drop", 32'(rd_valid), 0);
        chk("dout_hold", 32'(data_out), 0);
        rd_chk("gated_20", 0, 8'h20, 16'h0000);
        op(0, 1, 0, 8'hFF, 16'h1234);
        chk("wr_no_vld", 32'(rd_valid), 0);
        chk("wr_no_dout", 32'(data_out), 0);
        rd_chk("wrap_ff", 0, 8'hFF, 16'h1234);
        rd_chk("byte_00", 1, 8'h00, 16'h0034);
        rd_chk("byte_ff", 1, 8'hFF, 16'h0012);
        op(0, 1, 0, 8'h10, 16'hDEAD);
        op(0, 1, 1, 8'h11, 16'hFFBE);
        rd_chk("bytewr_10", 0, 8'h10, 16'hDEBE);
        rd_chk("unaligned_11", 0, 8'h11, 16'hBE00);
        op(0, 1, 0, 8'h30, 16'h5555);
        op(1, 1, 0, 8'h30, 16'hCAFE);
        chk("rmw_vld", 32'(rd_valid), 1);
        chk("rmw_old", 32'(data_out), 32'h5555);
        rd_chk("rmw_new", 0, 8'h30, 16'hCAFE);
        op(1, 1, 0, 8'h31, 16'h0102);
        chk("rmw_overlap", 32'(data_out), 32'hFE00);
        rd_chk("rmw_overlap_new", 0, 8'h30, 16'hCA01);
        // mid-init reset, then count edges to ready
        reset = 1'b0; #2 reset = 1'b1;
        chk("rst2_ready", 32'(ready), 0);
        for (int e = 1; e <= 60; e++) begin @(posedge clk); #1; end
        reset = 1'b0; #1;
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_dout", 32'(data_out), 0);
        #1 reset = 1'b1;
        rise = 0;
        for (int e = 1; e <= 300 && rise == 0; e++) begin
            @(posedge clk); #1;
            if (ready) rise = e;
        end
        chk("reinit_len", 32'(rise), 128);
`ifdef MEM_PRELOAD_EN
        rd_chk("pre_00", 0, 8'h00, 16'h2BCD);
        rd_chk("pre_06", 0, 8'h06, 16'hDEAD);
        rd_chk("pre_08", 0, 8'h08, 16'hBEEF);
`else
        rd_chk("pre_00", 0, 8'h00, 16'h0000);
        rd_chk("pre_06", 0, 8'h06, 16'h0000);
        rd_chk("pre_08", 0, 8'h08, 16'h0000);
`endif
        rd_chk("pre_0a", 0, 8'h0A, 16'h0000);
        rd_chk("cleared_30", 0, 8'h30, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
